// File: rtl/spi_slave_responder_if.sv
// -----------------------------------------------------------------------------
// spi_slave_responder_if
// Bundles the SPI pins and the CPU register port of spi_slave_responder.
//   SPI pins  : SCLK, SS_n, MOSI (from master), MISO, MISO_oe (to master)
//   CPU port  : spi_select, read_n, write_n, mem_addr[2:0], data_from_cpu[15:0]
//               (to responder); data_to_cpu[15:0], irq, dataavailable,
//               readyfordata (from responder)
// Modports: slave = the responder's view, master = the driving environment.
// -----------------------------------------------------------------------------
interface spi_slave_responder_if;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;
  logic        spi_select;
  logic        read_n;
  logic        write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;

  modport slave (
    input  SCLK, SS_n, MOSI, spi_select, read_n, write_n, mem_addr, data_from_cpu,
    output MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
  );

  modport master (
    output SCLK, SS_n, MOSI, spi_select, read_n, write_n, mem_addr, data_from_cpu,
    input  MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
  );
endinterface

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
// 16-bit SPI slave (CPOL=1, CPHA=1, MSB first) with a CPU register port.
// SCLK/SS_n/MOSI are oversampled in the clk domain (SCLK <= clk/8).
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   bus    : spi_slave_responder_if.slave (SPI pins + register port)
// Register map: 0 rx data (r), 1 tx data (w), 2 status (r, write clears),
//               3 control / interrupt enables (r/w).
// Status: [8] E, [7] RRDY, [6] TRDY, [5] TUR, [4] TOE, [3] ROE, [2] FE.
// -----------------------------------------------------------------------------
module spi_slave_responder (
  input  logic                  clk,
  input  logic                  reset,
  spi_slave_responder_if.slave  bus
);

  localparam int DATABITS = 16;

  // Synchronizers: [1] is the synchronized value, [2] the edge-detect history.
  logic [2:0]          sclk_q, sclk_d;
  logic [2:0]          ss_n_q, ss_n_d;
  logic [1:0]          mosi_q, mosi_d;
  logic                rd_prev_q, rd_prev_d;
  logic                wr_prev_q, wr_prev_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATABITS-1:0] tx_hold_q, tx_hold_d;
  logic [DATABITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATABITS-1:0] rx_hold_q, rx_hold_d;
  logic                trdy_q, trdy_d;
  logic                rrdy_q, rrdy_d;
  logic                tur_q, tur_d;
  logic                toe_q, toe_d;
  logic                roe_q, roe_d;
  logic                fe_q, fe_d;
  logic [8:2]          ctrl_q, ctrl_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic [DATABITS-1:0] data_to_cpu_q, data_to_cpu_d;
  logic                irq_q, irq_d;

  logic                fall_s, rise_s, sel_s, sel_on_s, sel_off_s, mosi_s;
  logic                rd_req_s, wr_req_s, rd_strobe_s, wr_strobe_s;
  logic                done_s, load_s;
  logic                rd_rx_s, wr_tx_s, wr_stat_s, wr_ctrl_s;
  logic [DATABITS-1:0] status_s;

  // Edge detection, access strobes and the decoded events of this cycle.
  always_comb begin
    fall_s      = sclk_q[2] & ~sclk_q[1];   // leading edge (CPOL=1)
    rise_s      = ~sclk_q[2] & sclk_q[1];   // trailing edge
    sel_s       = ~ss_n_q[1];
    sel_on_s    = sel_s & ss_n_q[2];
    sel_off_s   = ~sel_s & ~ss_n_q[2];
    mosi_s      = mosi_q[1];
    rd_req_s    = bus.spi_select & ~bus.read_n;
    wr_req_s    = bus.spi_select & ~bus.write_n;
    rd_strobe_s = rd_req_s & ~rd_prev_q;
    wr_strobe_s = wr_req_s & ~wr_prev_q;
    done_s      = sel_s & rise_s & (bitcnt_q == 4'd15);
    load_s      = sel_on_s | done_s;
    rd_rx_s     = rd_strobe_s & (bus.mem_addr == 3'd0);
    wr_tx_s     = wr_strobe_s & (bus.mem_addr == 3'd1);
    wr_stat_s   = wr_strobe_s & (bus.mem_addr == 3'd2);
    wr_ctrl_s   = wr_strobe_s & (bus.mem_addr == 3'd3);
    status_s    = {7'd0, (toe_q | tur_q | roe_q | fe_q), rrdy_q, trdy_q,
                   tur_q, toe_q, roe_q, fe_q, 2'b00};
  end

  // Next-state logic for the shift path, flags and register port.
  always_comb begin
    sclk_d    = {sclk_q[1:0], bus.SCLK};
    ss_n_d    = {ss_n_q[1:0], bus.SS_n};
    mosi_d    = {mosi_q[0], bus.MOSI};
    rd_prev_d = rd_req_s;
    wr_prev_d = wr_req_s;
    miso_oe_d = sel_s;

    // Leaving the frame always clears the count, which also drops a partial word.
    if (!sel_s) begin
      bitcnt_d = 4'd0;
    end else if (rise_s) begin
      bitcnt_d = done_s ? 4'd0 : (bitcnt_q + 4'd1);
    end else begin
      bitcnt_d = bitcnt_q;
    end

    if (sel_s && rise_s) begin
      rx_shift_d = {rx_shift_q[DATABITS-2:0], mosi_s};
    end else begin
      rx_shift_d = rx_shift_q;
    end

    rx_hold_d = done_s ? {rx_shift_q[DATABITS-2:0], mosi_s} : rx_hold_q;

    // Load uses the pre-load TRDY; an empty holding register sends zeros.
    if (load_s) begin
      tx_shift_d = trdy_q ? 16'h0000 : tx_hold_q;
    end else if (sel_s && fall_s) begin
      tx_shift_d = {tx_shift_q[DATABITS-2:0], 1'b0};
    end else begin
      tx_shift_d = tx_shift_q;
    end

    if (!sel_s) begin
      miso_d = 1'b1;
    end else if (fall_s) begin
      miso_d = tx_shift_q[DATABITS-1];
    end else begin
      miso_d = miso_q;
    end

    // CPU write and word load are judged against the same old TRDY, so they
    // never both change it in one cycle.
    if (wr_tx_s && trdy_q) begin
      trdy_d = 1'b0;
    end else if (load_s && !trdy_q) begin
      trdy_d = 1'b1;
    end else begin
      trdy_d = trdy_q;
    end

    tx_hold_d = (wr_tx_s && trdy_q) ? bus.data_from_cpu : tx_hold_q;

    // Set terms are ORed last so a coincident set beats the clear.
    toe_d  = (wr_tx_s & ~trdy_q) | (toe_q & ~wr_stat_s);
    tur_d  = (load_s & trdy_q) | (tur_q & ~wr_stat_s);
    roe_d  = (done_s & rrdy_q & ~rd_rx_s) | (roe_q & ~wr_stat_s);
    fe_d   = (sel_off_s & (bitcnt_q != 4'd0)) | (fe_q & ~wr_stat_s);
    rrdy_d = done_s | (rrdy_q & ~rd_rx_s & ~wr_stat_s);

    ctrl_d = wr_ctrl_s ? bus.data_from_cpu[8:2] : ctrl_q;

    if (rd_strobe_s) begin
      case (bus.mem_addr)
        3'd0:    data_to_cpu_d = rx_hold_q;
        3'd2:    data_to_cpu_d = status_s;
        3'd3:    data_to_cpu_d = {7'd0, ctrl_q, 2'b00};
        default: data_to_cpu_d = 16'h0000;
      endcase
    end else begin
      data_to_cpu_d = data_to_cpu_q;
    end

    irq_d = |(status_s[8:2] & ctrl_q);
  end

  // State registers with asynchronous reset to the documented idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q        <= 3'b111;
      ss_n_q        <= 3'b111;
      mosi_q        <= 2'b00;
      rd_prev_q     <= 1'b0;
      wr_prev_q     <= 1'b0;
      bitcnt_q      <= 4'd0;
      tx_shift_q    <= 16'h0000;
      tx_hold_q     <= 16'h0000;
      rx_shift_q    <= 16'h0000;
      rx_hold_q     <= 16'h0000;
      trdy_q        <= 1'b1;
      rrdy_q        <= 1'b0;
      tur_q         <= 1'b0;
      toe_q         <= 1'b0;
      roe_q         <= 1'b0;
      fe_q          <= 1'b0;
      ctrl_q        <= 7'd0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
      data_to_cpu_q <= 16'h0000;
      irq_q         <= 1'b0;
    end else begin
      sclk_q        <= sclk_d;
      ss_n_q        <= ss_n_d;
      mosi_q        <= mosi_d;
      rd_prev_q     <= rd_prev_d;
      wr_prev_q     <= wr_prev_d;
      bitcnt_q      <= bitcnt_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      rx_shift_q    <= rx_shift_d;
      rx_hold_q     <= rx_hold_d;
      trdy_q        <= trdy_d;
      rrdy_q        <= rrdy_d;
      tur_q         <= tur_d;
      toe_q         <= toe_d;
      roe_q         <= roe_d;
      fe_q          <= fe_d;
      ctrl_q        <= ctrl_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      data_to_cpu_q <= data_to_cpu_d;
      irq_q         <= irq_d;
    end
  end

  assign bus.MISO          = miso_q;
  assign bus.MISO_oe       = miso_oe_q;
  assign bus.data_to_cpu   = data_to_cpu_q;
  assign bus.irq           = irq_q;
  assign bus.dataavailable = rrdy_q;
  assign bus.readyfordata  = trdy_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
// Directed bench: plays a CPOL=1/CPHA=1 master at clk/8 and a CPU on the
// register port; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [15:0] rx_w;
  logic [15:0] rd_w;

  spi_slave_responder_if bus_if ();

  spi_slave_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_if.spi_select    = 1'b1;
    bus_if.write_n       = 1'b0;
    bus_if.mem_addr      = a;
    bus_if.data_from_cpu = d;
    @(negedge clk);
    bus_if.write_n    = 1'b1;
    bus_if.spi_select = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_if.spi_select = 1'b1;
    bus_if.read_n     = 1'b0;
    bus_if.mem_addr   = a;
    @(negedge clk);
    d = bus_if.data_to_cpu;
    bus_if.read_n     = 1'b1;
    bus_if.spi_select = 1'b0;
  endtask

  // Sends n bits MSB first; each SCLK half period is 4 clk.
  task automatic spi_bits(input int n, input logic [15:0] tx, output logic [15:0] rx);
    rx = 16'h0000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.SCLK = 1'b0;
      bus_if.MOSI = tx[15-i];
      repeat (3) @(negedge clk);
      rx = {rx[14:0], bus_if.MISO};
      bus_if.SCLK = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    bus_if.SS_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    bus_if.SS_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    tests_run            = 0;
    tests_failed         = 0;
    reset                = 1'b1;
    bus_if.SCLK          = 1'b1;
    bus_if.SS_n          = 1'b1;
    bus_if.MOSI          = 1'b0;
    bus_if.spi_select    = 1'b0;
    bus_if.read_n        = 1'b1;
    bus_if.write_n       = 1'b1;
    bus_if.mem_addr      = 3'd0;
    bus_if.data_from_cpu = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset in the middle of a frame ----
    cpu_write(3'd3, 16'h01FC);
    cpu_read(3'd3, rd_w);
    check("ctrl_readback", rd_w, 16'h01FC);
    cpu_write(3'd1, 16'h00FF);
    frame_begin();
    cpu_write(3'd1, 16'h7777);
    spi_bits(5, 16'h0000, rx_w);
    check("pre_reset_oe", {15'd0, bus_if.MISO_oe}, 16'h0001);
    reset = 1'b1;
    @(negedge clk);
    check("rst_miso", {15'd0, bus_if.MISO}, 16'h0001);
    check("rst_miso_oe", {15'd0, bus_if.MISO_oe}, 16'h0000);
    check("rst_trdy", {15'd0, bus_if.readyfordata}, 16'h0001);
    check("rst_rrdy", {15'd0, bus_if.dataavailable}, 16'h0000);
    check("rst_irq", {15'd0, bus_if.irq}, 16'h0000);
    check("rst_data", bus_if.data_to_cpu, 16'h0000);
    bus_if.SS_n = 1'b1;
    bus_if.SCLK = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    cpu_read(3'd2, rd_w);
    check("rst_status_no_fe", rd_w, 16'h0040);
    cpu_read(3'd3, rd_w);
    check("rst_ctrl", rd_w, 16'h0000);

    // ---- single word ----
    cpu_write(3'd1, 16'hA5C3);
    check("single_trdy_low", {15'd0, bus_if.readyfordata}, 16'h0000);
    frame_begin();
    check("single_trdy_reload", {15'd0, bus_if.readyfordata}, 16'h0001);
    check("single_oe", {15'd0, bus_if.MISO_oe}, 16'h0001);
    spi_bits(16, 16'h1234, rx_w);
    check("single_miso_word", rx_w, 16'hA5C3);
    frame_end();
    check("single_oe_off", {15'd0, bus_if.MISO_oe}, 16'h0000);
    check("single_rrdy", {15'd0, bus_if.dataavailable}, 16'h0001);
    cpu_read(3'd0, rd_w);
    check("single_rx", rd_w, 16'h1234);
    check("single_rrdy_clr", {15'd0, bus_if.dataavailable}, 16'h0000);
    cpu_read(3'd2, rd_w);
    check("single_status", rd_w, 16'h0160);
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2, rd_w);
    check("single_status_clr", rd_w, 16'h0040);

    // ---- back-to-back words ----
    cpu_write(3'd1, 16'h1111);
    frame_begin();
    cpu_write(3'd1, 16'h2222);
    spi_bits(16, 16'hABCD, rx_w);
    check("b2b_word1", rx_w, 16'h1111);
    cpu_read(3'd0, rd_w);
    check("b2b_rx1", rd_w, 16'hABCD);
    cpu_write(3'd1, 16'h3333);
    spi_bits(16, 16'h5A5A, rx_w);
    check("b2b_word2", rx_w, 16'h2222);
    frame_end();
    cpu_read(3'd2, rd_w);
    check("b2b_status", rd_w, 16'h00C0);
    cpu_read(3'd0, rd_w);
    check("b2b_rx2", rd_w, 16'h5A5A);

    // ---- underrun with iTUR ----
    cpu_write(3'd3, 16'h0020);
    frame_begin();
    check("tur_irq", {15'd0, bus_if.irq}, 16'h0001);
    spi_bits(16, 16'h0F0F, rx_w);
    check("tur_miso_zero", rx_w, 16'h0000);
    cpu_read(3'd2, rd_w);
    check("tur_status", rd_w, 16'h01E0);
    frame_end();
    cpu_read(3'd0, rd_w);
    check("tur_rx", rd_w, 16'h0F0F);
    cpu_write(3'd2, 16'h0000);
    @(negedge clk);
    check("tur_irq_clr", {15'd0, bus_if.irq}, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // ---- overrun then frame error ----
    frame_begin();
    spi_bits(16, 16'h1357, rx_w);
    spi_bits(16, 16'h2468, rx_w);
    cpu_read(3'd2, rd_w);
    check("roe_status", rd_w, 16'h01E8);
    spi_bits(7, 16'hFFFF, rx_w);
    frame_end();
    cpu_read(3'd2, rd_w);
    check("fe_status", rd_w, 16'h01EC);
    check("fe_rrdy_kept", {15'd0, bus_if.dataavailable}, 16'h0001);
    cpu_read(3'd0, rd_w);
    check("fe_rx_kept", rd_w, 16'h2468);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd_w);
    check("flags_clr", rd_w, 16'h0040);

    // ---- completion coincident with rx read ----
    frame_begin();
    spi_bits(16, 16'h0001, rx_w);
    spi_bits(15, 16'h8000, rx_w);
    @(negedge clk);
    bus_if.SCLK = 1'b0;
    bus_if.MOSI = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.SCLK = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.spi_select = 1'b1;
    bus_if.read_n     = 1'b0;
    bus_if.mem_addr   = 3'd0;
    @(negedge clk);
    rd_w = bus_if.data_to_cpu;
    bus_if.read_n     = 1'b1;
    bus_if.spi_select = 1'b0;
    check("simul_rx_old", rd_w, 16'h0001);
    check("simul_rrdy", {15'd0, bus_if.dataavailable}, 16'h0001);
    cpu_read(3'd2, rd_w);
    check("simul_no_roe", rd_w, 16'h01E0);
    frame_end();
    cpu_read(3'd0, rd_w);
    check("simul_rx_new", rd_w, 16'h8000);
    cpu_write(3'd2, 16'h0000);

    // ---- write while holding full ----
    cpu_write(3'd1, 16'hBEEF);
    cpu_write(3'd1, 16'hDEAD);
    cpu_read(3'd2, rd_w);
    check("toe_status", rd_w, 16'h0110);
    frame_begin();
    spi_bits(16, 16'h0000, rx_w);
    check("toe_hold_kept", rx_w, 16'hBEEF);
    frame_end();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
